// File: rtl/spi_master_ctrl.sv
// Single-byte SPI mode-0 master (CPOL=0, CPHA=0, MSB first): one accepted start pulse
// produces one chip-select framed byte, with a done pulse and, for RECEIVE, a data-valid strobe.
//
// state | meaning
// IDLE  | cs_n high, waiting for start with a valid mode
// SETUP | cs_n low, first TX bit on mosi, sclk low for H cycles
// SHIFT | 8 bits of sclk low/high, H cycles each phase
// HOLD  | sclk low, cs_n low, mosi held, H cycles
// DONE  | one cycle: done pulse, data_out update on RECEIVE
module spi_master_ctrl #(
    parameter int                    CLKS_PER_HALF_BIT = 2,
    parameter int                    W_SPI_MODE        = 2,
    parameter logic [W_SPI_MODE-1:0] SPI_SEND          = W_SPI_MODE'(1),
    parameter logic [W_SPI_MODE-1:0] SPI_RECEIVE       = W_SPI_MODE'(2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W_SPI_MODE-1:0] control_rd,
    input  logic                  start,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  dv_data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam int               DIV_W      = $clog2(CLKS_PER_HALF_BIT) + 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             sclk_q, sclk_d;
    logic             recv_q, recv_d;

    logic mode_valid;
    logic div_zero;

    assign mode_valid = (control_rd == SPI_SEND) || (control_rd == SPI_RECEIVE);
    assign div_zero   = (div_q == '0);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        sclk_d     = sclk_q;
        recv_d     = recv_q;

        case (state_q)
            ST_IDLE: begin
                if (start && mode_valid) begin
                    state_d = ST_SETUP;
                    recv_d  = (control_rd == SPI_RECEIVE);
                    tx_d    = (control_rd == SPI_RECEIVE) ? 8'h00 : data_in;
                    rx_d    = 8'h00;
                    bit_d   = 3'd7;
                    div_d   = DIV_RELOAD;
                    sclk_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (div_zero) begin
                    state_d = ST_SHIFT;
                    div_d   = DIV_RELOAD;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            ST_SHIFT: begin
                if (!div_zero) begin
                    div_d = div_q - DIV_ONE;
                end else if (!sclk_q) begin
                    // rising sclk edge doubles as the RX sample point
                    sclk_d = 1'b1;
                    div_d  = DIV_RELOAD;
                    rx_d   = {rx_q[6:0], miso};
                end else begin
                    sclk_d = 1'b0;
                    div_d  = DIV_RELOAD;
                    if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (div_zero) begin
                    state_d = ST_DONE;
                    div_d   = DIV_RELOAD;
                    if (recv_q) begin
                        data_out_d = rx_q;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                div_d   = DIV_RELOAD;
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= 3'd0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            data_out_q <= 8'h00;
            sclk_q     <= 1'b0;
            recv_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            sclk_q     <= sclk_d;
            recv_q     <= recv_d;
        end
    end

    assign busy        = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign cs_n        = ~busy;
    assign done        = (state_q == ST_DONE);
    assign dv_data_out = done & recv_q;
    assign sclk        = sclk_q;
    assign mosi        = busy & tx_q[7];
    assign data_out    = data_out_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with H=2: a vector table of single frames plus
// hand-written sequences for mid-frame start, invalid modes, mid-frame reset and back-to-back frames.
module tb_spi_master_ctrl;

    localparam int         H    = 2;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] RECV = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] control_rd = 2'd0;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       dv_data_out;
    logic       done;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso = 1'b0;
    logic       cs_n;

    spi_master_ctrl #(
        .CLKS_PER_HALF_BIT(H),
        .W_SPI_MODE       (2),
        .SPI_SEND         (SEND),
        .SPI_RECEIVE      (RECV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .control_rd (control_rd),
        .start      (start),
        .data_in    (data_in),
        .data_out   (data_out),
        .dv_data_out(dv_data_out),
        .done       (done),
        .busy       (busy),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pin monitor / SPI slave model, sampled 1 time unit after each rising clk edge
    int         rise_cnt = 0;
    int         mosi_high_cnt = 0;
    int         done_cnt = 0;
    int         dv_cnt = 0;
    logic [7:0] mosi_bits = 8'h00;
    logic [7:0] cur_miso = 8'h00;
    int         miso_idx = 8;
    logic       sclk_prev = 1'b0;
    logic       cs_prev = 1'b1;

    always @(posedge clk) begin
        #1;
        if (sclk && !sclk_prev) begin
            rise_cnt++;
            mosi_bits = {mosi_bits[6:0], mosi};
        end
        if (mosi) mosi_high_cnt++;
        if (done) done_cnt++;
        if (dv_data_out) dv_cnt++;
        if (!cs_n && cs_prev) begin
            miso     = cur_miso[7];
            miso_idx = 1;
        end else if (!sclk && sclk_prev && miso_idx < 8) begin
            miso = cur_miso[7 - miso_idx];
            miso_idx++;
        end
        sclk_prev = sclk;
        cs_prev   = cs_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon(input logic [7:0] mb);
        rise_cnt      = 0;
        mosi_high_cnt = 0;
        done_cnt      = 0;
        dv_cnt        = 0;
        mosi_bits     = 8'h00;
        cur_miso      = mb;
    endtask

    // Returns with the bench at the negedge right after the accepting edge; c0 is that cycle
    task automatic start_frame(input logic [1:0] mode, input logic [7:0] tx, input logic [7:0] mb,
                               output int c0);
        clear_mon(mb);
        @(negedge clk);
        control_rd = mode;
        data_in    = tx;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
    endtask

    task automatic wait_done(input string name, input int c0, output int lat);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - c0;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout actual=none expected=done within 200 cycles", name);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] tx;
        logic [7:0] miso_byte;
        logic       exp_dv;
        logic [7:0] exp_dout;
        logic [7:0] exp_mosi;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int c0, lat;
        start_frame(v.mode, v.tx, v.miso_byte, c0);
        check({tag, "_busy_cs"}, 32'({busy, cs_n}), 32'(2'b10));
        wait_done(tag, c0, lat);
        check({tag, "_latency"}, 32'(lat), 32'(18 * H));
        check({tag, "_dv"}, 32'(dv_data_out), 32'(v.exp_dv));
        check({tag, "_data_out"}, 32'(data_out), 32'(v.exp_dout));
        @(negedge clk);
        check({tag, "_pulse_width"}, 32'({done, dv_data_out, cs_n}), 32'(3'b001));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
        check({tag, "_dv_cnt"}, 32'(dv_cnt), 32'(v.exp_dv));
        check({tag, "_sclk_rises"}, 32'(rise_cnt), 32'(8));
        check({tag, "_mosi_bits"}, 32'(mosi_bits), 32'(v.exp_mosi));
        if (v.mode == RECV) check({tag, "_mosi_low"}, 32'(mosi_high_cnt), 32'(0));
    endtask

    vec_t vecs[6];

    initial begin
        int c0, c1, lat, cs_hi;
        vec_t v81;

        vecs[0] = '{SEND, 8'hA5, 8'hFF, 1'b0, 8'h00, 8'hA5};
        vecs[1] = '{RECV, 8'hFF, 8'h3C, 1'b1, 8'h3C, 8'h00};
        vecs[2] = '{SEND, 8'h5A, 8'h00, 1'b0, 8'h3C, 8'h5A};
        vecs[3] = '{RECV, 8'hAA, 8'hC3, 1'b1, 8'hC3, 8'h00};
        vecs[4] = '{SEND, 8'hFF, 8'h55, 1'b0, 8'hC3, 8'hFF};
        vecs[5] = '{RECV, 8'h00, 8'h96, 1'b1, 8'h96, 8'h00};
        v81     = '{RECV, 8'h00, 8'h81, 1'b1, 8'h81, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_pins", 32'({sclk, mosi, cs_n, busy, done, dv_data_out}), 32'(6'b001000));
        check("reset_data_out", 32'(data_out), 32'(8'h00));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Second start ten cycles into a SEND must be ignored
        start_frame(SEND, 8'hC3, 8'h00, c0);
        repeat (10) @(negedge clk);
        control_rd = RECV;
        data_in    = 8'h00;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midstart", c0, lat);
        check("midstart_latency", 32'(lat), 32'(18 * H));
        check("midstart_dv", 32'(dv_data_out), 32'(0));
        repeat (40) @(negedge clk);
        check("midstart_done_cnt", 32'(done_cnt), 32'(1));
        check("midstart_sclk_rises", 32'(rise_cnt), 32'(8));
        check("midstart_mosi_bits", 32'(mosi_bits), 32'(8'hC3));
        check("midstart_idle", 32'({busy, cs_n}), 32'(2'b01));

        // Invalid modes in IDLE
        for (int m = 0; m < 4; m += 3) begin
            clear_mon(8'h00);
            @(negedge clk);
            control_rd = 2'(m);
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("invalid_mode%0d_busy", m), 32'({busy, cs_n}), 32'(2'b01));
            repeat (6) @(negedge clk);
            check($sformatf("invalid_mode%0d_rises", m), 32'(rise_cnt), 32'(0));
        end

        // Reset twenty cycles into a RECEIVE
        start_frame(RECV, 8'h00, 8'hE7, c0);
        repeat (20) @(negedge clk);
        check("rstmid_sclk_before", 32'({sclk, cs_n}), 32'(2'b10));
        rst_n = 1'b0;
        #1;
        check("rstmid_pins", 32'({cs_n, sclk, busy, mosi}), 32'(4'b1000));
        check("rstmid_data_out", 32'(data_out), 32'(8'h00));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("rstmid_no_done", 32'({done_cnt[15:0], dv_cnt[15:0]}), 32'(0));
        run_vec(v81, "after_rst");

        // Back-to-back with start held high: RECEIVE 0xF0, then SEND 0x0F
        clear_mon(8'hF0);
        @(negedge clk);
        control_rd = RECV;
        data_in    = 8'h55;
        start      = 1'b1;
        @(negedge clk);
        c0 = cyc;
        wait_done("b2b_rx", c0, lat);
        check("b2b_rx_latency", 32'(lat), 32'(18 * H));
        check("b2b_rx_data", 32'({dv_data_out, data_out}), 32'({1'b1, 8'hF0}));
        check("b2b_rx_rises", 32'(rise_cnt), 32'(8));
        control_rd = SEND;
        data_in    = 8'h0F;
        clear_mon(8'hFF);
        cs_hi = 1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (cs_n) cs_hi++;
            else break;
        end
        // cs_n stays high across the DONE cycle plus exactly one IDLE cycle
        check("b2b_cs_high_cycles", 32'(cs_hi), 32'(2));
        c1 = cyc;
        check("b2b_gap_from_done", 32'(c1 - (c0 + 18 * H)), 32'(2));
        check("b2b_tx_busy", 32'(busy), 32'(1));
        wait_done("b2b_tx", c1, lat);
        start = 1'b0;
        check("b2b_tx_latency", 32'(lat), 32'(18 * H));
        check("b2b_tx_data", 32'({dv_data_out, data_out}), 32'({1'b0, 8'hF0}));
        check("b2b_tx_mosi_bits", 32'(mosi_bits), 32'(8'h0F));
        check("b2b_tx_rises", 32'(rise_cnt), 32'(8));
        repeat (5) @(negedge clk);
        check("b2b_end_idle", 32'({busy, cs_n, sclk}), 32'(3'b010));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
